// File: rtl/clock_select_ctrl_pkg.sv
// Shared definitions for the clock select controller: FSM state encoding,
// parameter defaults, select encoding and the wait-timer compare helper.
package clock_select_ctrl_pkg;

    // Controller states; IDLE is the only state that accepts a request.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_ISSUE        = 2'd1,
        ST_WAIT_ASSERT  = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_e;

    // Default synchronizer depth for the selector reset feedback.
    localparam int SYNC_STAGES_DEF = 2;

    // Default wait-state cycle limit.
    localparam int TIMEOUT_DEF = 255;

    // Width of the wait timer; TIMEOUT must fit in it.
    localparam int TIMER_W = 8;

    // Select encoding shared with the clock selector.
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    // True when the incremented wait timer has reached the limit.
    function automatic logic timer_hit(input logic [TIMER_W-1:0] count,
                                       input logic [TIMER_W-1:0] limit);
        return (count == limit);
    endfunction

endpackage

// File: rtl/clock_select_ctrl_sel_rst_sync.sv
// Synchronizer for the selector's active-low output reset. SEL_RST is
// asynchronous to CLK; the chain is cleared to 0 (reset asserted) by RST_N.
module sel_rst_sync
    import clock_select_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic SEL_RST,
    output logic SEL_RST_SYNC
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift the raw selector reset level through the synchronizer chain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], SEL_RST};
        end
    end

    assign SEL_RST_SYNC = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/clock_select_ctrl.sv
// Clock select controller. Accepts a switch request, loads SELECT into the
// clock selector with a one-cycle SELECT_ENABLE, then follows the selector's
// output reset (assert, then release) to confirm the switch. A wait that
// exceeds TIMEOUT cycles ends with an ERROR pulse instead of a hang.
module clock_select_ctrl
    import clock_select_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic REQ_VALID,
    input  logic REQ_SEL,
    output logic REQ_READY,
    output logic SELECT,
    output logic SELECT_ENABLE,
    input  logic SEL_RST,
    output logic CUR_SEL,
    output logic BUSY,
    output logic DONE,
    output logic ERROR
);

    localparam logic [TIMER_W-1:0] TIMEOUT_C = TIMER_W'(TIMEOUT);

    state_e               state_r;
    state_e               state_s;
    logic                 target_r;
    logic                 target_s;
    logic                 select_r;
    logic                 select_s;
    logic                 sel_en_r;
    logic                 sel_en_s;
    logic                 cur_sel_r;
    logic                 cur_sel_s;
    logic                 done_r;
    logic                 done_s;
    logic                 error_r;
    logic                 error_s;
    logic [TIMER_W-1:0]   timer_r;
    logic [TIMER_W-1:0]   timer_s;
    logic [TIMER_W-1:0]   timer_inc_s;
    logic                 sel_rst_sync_s;

    // Selector reset feedback brought into the CLK domain.
    sel_rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sel_rst_sync (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .SEL_RST      (SEL_RST),
        .SEL_RST_SYNC (sel_rst_sync_s)
    );

    assign timer_inc_s = timer_r + 8'd1;

    // Next-state and next-output decode; outputs are registered below so
    // DONE/ERROR/SELECT_ENABLE never depend combinationally on SEL_RST.
    always_comb begin
        state_s   = state_r;
        target_s  = target_r;
        select_s  = select_r;
        sel_en_s  = 1'b0;
        cur_sel_s = cur_sel_r;
        done_s    = 1'b0;
        error_s   = 1'b0;
        timer_s   = timer_r;

        case (state_r)
            ST_IDLE: begin
                timer_s = 8'd0;
                if (REQ_VALID) begin
                    if (REQ_SEL == cur_sel_r) begin
                        // Already on the requested clock: complete at once.
                        done_s = 1'b1;
                    end else begin
                        // SELECT changes only here, together with the enable
                        // strobe that the ISSUE cycle presents.
                        target_s = REQ_SEL;
                        select_s = REQ_SEL;
                        sel_en_s = 1'b1;
                        state_s  = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                timer_s = 8'd0;
                state_s = ST_WAIT_ASSERT;
            end

            ST_WAIT_ASSERT: begin
                if (!sel_rst_sync_s) begin
                    timer_s = 8'd0;
                    state_s = ST_WAIT_RELEASE;
                end else if (timer_hit(timer_inc_s, TIMEOUT_C)) begin
                    // The selector already latched SELECT, so track it anyway.
                    error_s   = 1'b1;
                    cur_sel_s = target_r;
                    timer_s   = 8'd0;
                    state_s   = ST_IDLE;
                end else begin
                    timer_s = timer_inc_s;
                end
            end

            ST_WAIT_RELEASE: begin
                if (sel_rst_sync_s) begin
                    done_s    = 1'b1;
                    cur_sel_s = target_r;
                    timer_s   = 8'd0;
                    state_s   = ST_IDLE;
                end else if (timer_hit(timer_inc_s, TIMEOUT_C)) begin
                    error_s   = 1'b1;
                    cur_sel_s = target_r;
                    timer_s   = 8'd0;
                    state_s   = ST_IDLE;
                end else begin
                    timer_s = timer_inc_s;
                end
            end

            default: begin
                timer_s = 8'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, timer and registered outputs; reset matches the selector's
    // own reset choice of the B clock.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r   <= ST_IDLE;
            target_r  <= SEL_B;
            select_r  <= SEL_B;
            sel_en_r  <= 1'b0;
            cur_sel_r <= SEL_B;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            timer_r   <= 8'd0;
        end else begin
            state_r   <= state_s;
            target_r  <= target_s;
            select_r  <= select_s;
            sel_en_r  <= sel_en_s;
            cur_sel_r <= cur_sel_s;
            done_r    <= done_s;
            error_r   <= error_s;
            timer_r   <= timer_s;
        end
    end

    assign REQ_READY     = (state_r == ST_IDLE);
    assign BUSY          = (state_r != ST_IDLE);
    assign SELECT        = select_r;
    assign SELECT_ENABLE = sel_en_r;
    assign CUR_SEL       = cur_sel_r;
    assign DONE          = done_r;
    assign ERROR         = error_r;

endmodule

// File: tb/tb_clock_select_ctrl.sv
// Scoreboard bench for clock_select_ctrl. Stimulus pushes the expected
// SELECT_ENABLE / DONE / ERROR events (kind, cycle, value, ready) into a
// queue; a negedge monitor pops and compares whenever the DUT pulses one.
// The selector model drops SEL_RST on the negedge it sees SELECT_ENABLE and
// holds it low for hold_len negedges, so for a switch with SYNC_STAGES=2:
//   DONE cycle  = request cycle + 1 + SYNC + hold_len
//   ERROR (stuck high) = request cycle + 1 + TMO
//   ERROR (stuck low)  = request cycle + 1 + SYNC + TMO
module tb_clock_select_ctrl;
    import clock_select_ctrl_pkg::*;

    localparam int SYNC = 2;
    localparam int TMO  = 10;

    localparam int K_EN   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;
    localparam int K_NONE = -1;

    localparam int M_NORMAL     = 0;
    localparam int M_STUCK_HIGH = 1;
    localparam int M_STUCK_LOW  = 2;

    logic CLK       = 1'b0;
    logic RST_N     = 1'b1;
    logic REQ_VALID = 1'b0;
    logic REQ_SEL   = 1'b0;
    logic SEL_RST   = 1'b1;
    logic REQ_READY;
    logic SELECT;
    logic SELECT_ENABLE;
    logic CUR_SEL;
    logic BUSY;
    logic DONE;
    logic ERROR;

    typedef struct {
        int   kind;
        int   cyc;
        logic val;
        logic rdy;
    } ev_t;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  checks   = 0;
    int  passes   = 0;
    int  sel_mode = M_NORMAL;
    int  hold_len = 5;
    int  hold_cnt = 0;
    logic prev_sel    = 1'b0;
    logic prev_rst_ok = 1'b0;

    clock_select_ctrl #(
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TMO)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .REQ_VALID     (REQ_VALID),
        .REQ_SEL       (REQ_SEL),
        .REQ_READY     (REQ_READY),
        .SELECT        (SELECT),
        .SELECT_ENABLE (SELECT_ENABLE),
        .SEL_RST       (SEL_RST),
        .CUR_SEL       (CUR_SEL),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .ERROR         (ERROR)
    );

    always #5 CLK = ~CLK;

    // Cycle index: after posedge k, cyc == k.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push(input int kind, input int c, input logic val, input logic rdy);
        ev_t e;
        e.kind = kind; e.cyc = c; e.val = val; e.rdy = rdy;
        exp_q.push_back(e);
    endtask

    task automatic mon_event(input int kind, input logic val, input logic rdy);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind",  kind,      e.kind);
            chk("event_cycle", cyc,       e.cyc);
            chk("event_value", int'(val), int'(e.val));
            chk("event_ready", int'(rdy), int'(e.rdy));
        end
    endtask

    // Monitor: compare every output pulse against the scoreboard and check
    // that SELECT only moves together with SELECT_ENABLE.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (SELECT_ENABLE) mon_event(K_EN,   SELECT,  REQ_READY);
            if (DONE)          mon_event(K_DONE, CUR_SEL, REQ_READY);
            if (ERROR)         mon_event(K_ERR,  CUR_SEL, REQ_READY);
            if (prev_rst_ok && (SELECT !== prev_sel))
                chk("select_moves_with_enable", int'(SELECT_ENABLE), 1);
        end
        prev_sel    <= SELECT;
        prev_rst_ok <= RST_N;
    end

    // Clock selector model driving SEL_RST.
    always @(negedge CLK) begin
        if (SELECT_ENABLE && (sel_mode != M_STUCK_HIGH)) begin
            SEL_RST  = 1'b0;
            hold_cnt = hold_len;
        end else if (sel_mode != M_STUCK_LOW) begin
            if (hold_cnt > 0) hold_cnt = hold_cnt - 1;
            if (hold_cnt == 0) SEL_RST = 1'b1;
        end
    end

    // Issue one request at the next posedge; expected events are queued first.
    task automatic issue(input logic sel, input logic sw, input int end_kind,
                         input int lat, output int r);
        @(negedge CLK);
        chk("ready_before_req", int'(REQ_READY), 1);
        r = cyc + 1;
        if (sw) push(K_EN, r, sel, 1'b0);
        if (end_kind != K_NONE) push(end_kind, r + lat, sel, 1'b1);
        REQ_VALID = 1'b1;
        REQ_SEL   = sel;
        @(negedge CLK);
        REQ_VALID = 1'b0;
    endtask

    // Wait (bounded) for all expected events, then linger for stray ones.
    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge CLK);
            n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        int r;

        // Reset values
        #2 RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_select",     int'(SELECT),        0);
        chk("rst_cur_sel",    int'(CUR_SEL),       0);
        chk("rst_sel_enable", int'(SELECT_ENABLE), 0);
        chk("rst_done",       int'(DONE),          0);
        chk("rst_error",      int'(ERROR),         0);
        chk("rst_busy",       int'(BUSY),          0);
        chk("rst_ready",      int'(REQ_READY),     1);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);

        // Request for the clock already selected: DONE next cycle, no enable
        issue(SEL_B, 1'b0, K_DONE, 0, r);
        drain(10, "same_sel_drain");
        chk("same_sel_cur", int'(CUR_SEL), 0);

        // Switch to A with a 5-cycle selector reset
        hold_len = 5;
        issue(SEL_A, 1'b1, K_DONE, 1 + SYNC + 5, r);
        chk("switch_busy", int'(BUSY), 1);
        drain(30, "switch_a_drain");
        chk("switch_a_select", int'(SELECT),  1);
        chk("switch_a_cur",    int'(CUR_SEL), 1);

        // Switch back to B; a second request pulsed while busy is ignored
        issue(SEL_B, 1'b1, K_DONE, 1 + SYNC + 5, r);
        @(negedge CLK);
        chk("busy_ready_low", int'(REQ_READY), 0);
        REQ_VALID = 1'b1;
        REQ_SEL   = SEL_A;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        drain(30, "busy_ignore_drain");
        chk("busy_ignore_cur",    int'(CUR_SEL), 0);
        chk("busy_ignore_select", int'(SELECT),  0);

        // SEL_RST stuck high: ERROR TMO cycles after leaving ISSUE
        sel_mode = M_STUCK_HIGH;
        issue(SEL_A, 1'b1, K_ERR, 1 + TMO, r);
        drain(TMO + 10, "stuck_high_drain");
        chk("stuck_high_cur",   int'(CUR_SEL),   1);
        chk("stuck_high_ready", int'(REQ_READY), 1);
        sel_mode = M_NORMAL;

        // SEL_RST stuck low: ERROR from the release wait
        sel_mode = M_STUCK_LOW;
        issue(SEL_B, 1'b1, K_ERR, 1 + SYNC + TMO, r);
        drain(TMO + 15, "stuck_low_drain");
        chk("stuck_low_cur", int'(CUR_SEL), 0);
        sel_mode = M_NORMAL;
        repeat (12) @(negedge CLK);

        // One-cycle SEL_RST pulse still completes without hanging
        hold_len = 1;
        issue(SEL_A, 1'b1, K_DONE, 1 + SYNC + 1, r);
        drain(TMO + 2, "short_pulse_drain");
        chk("short_pulse_cur", int'(CUR_SEL), 1);

        // Reset during WAIT_RELEASE aborts the switch
        hold_len = 8;
        issue(SEL_B, 1'b1, K_NONE, 0, r);
        repeat (4) @(negedge CLK);
        chk("abort_busy_before_rst", int'(BUSY), 1);
        #1 RST_N = 1'b0;
        #1;
        chk("abort_cur_sel", int'(CUR_SEL),       0);
        chk("abort_select",  int'(SELECT),        0);
        chk("abort_enable",  int'(SELECT_ENABLE), 0);
        chk("abort_done",    int'(DONE),          0);
        chk("abort_error",   int'(ERROR),         0);
        chk("abort_busy",    int'(BUSY),          0);
        repeat (3) @(negedge CLK);
        chk("abort_queue_empty", exp_q.size(), 0);
        // Release and request on the very first posedge
        RST_N = 1'b1;
        chk("post_rst_ready", int'(REQ_READY), 1);
        r = cyc + 1;
        push(K_DONE, r, SEL_B, 1'b1);
        REQ_VALID = 1'b1;
        REQ_SEL   = SEL_B;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        drain(10, "post_rst_drain");
        repeat (8) @(negedge CLK);

        // Normal switch after the aborted one
        hold_len = 5;
        issue(SEL_A, 1'b1, K_DONE, 1 + SYNC + 5, r);
        drain(30, "post_rst_switch_drain");
        chk("post_rst_switch_cur", int'(CUR_SEL), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
